// File: rtl/fire_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : fire_sequencer
// Brief    : Debounced fire/mode front end, shot strobe, shot budget and
//            game-end evaluation for the 4x4 battleship cell array.
// Revision : 1.0
// ============================================================================
module fire_sequencer #(
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int MAX_SHOTS       = 10,
    parameter int SETTLE_CYCLES   = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        fire_btn_raw,
    input  logic        nrow_raw,
    input  logic [3:0]  sel_onehot,
    input  logic        sel_error,
    input  logic [31:0] grid_state,
    output logic [3:0]  row_en,
    output logic [3:0]  col_en,
    output logic        fire_pulse,
    output logic        reject,
    output logic [3:0]  shots_left,
    output logic        game_over,
    output logic        win,
    output logic        busy
);

    localparam int              c_DB_W        = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [c_DB_W-1:0] c_DB_LAST   = c_DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [3:0]      c_SETTLE_LAST = 4'(SETTLE_CYCLES - 1);
    localparam logic [3:0]      c_MAX_SHOTS   = 4'(MAX_SHOTS);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FIRE   = 3'd1,
        S_SETTLE = 3'd2,
        S_EVAL   = 3'd3,
        S_DONE   = 3'd4
    } state_t;

    // Bit 0 carries the fire button, bit 1 the row/column mode switch.
    logic [1:0] w_raw;
    logic [1:0] w_deb;
    assign w_raw = {nrow_raw, fire_btn_raw};

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_cond
            logic              r_s1;
            logic              r_s2;
            logic              r_deb;
            logic [c_DB_W-1:0] r_cnt;

            always_ff @(posedge clk) begin
                if (reset) begin
                    r_s1  <= 1'b0;
                    r_s2  <= 1'b0;
                    r_deb <= 1'b0;
                    r_cnt <= '0;
                end else begin
                    r_s1 <= w_raw[gi];
                    r_s2 <= r_s1;
                    if (r_s2 == r_deb) begin
                        r_cnt <= '0;
                    end else if (r_cnt == c_DB_LAST) begin
                        r_deb <= r_s2;
                        r_cnt <= '0;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
            end

            assign w_deb[gi] = r_deb;
        end
    endgenerate

    logic r_fire_deb_d;
    logic w_fire_rise;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_fire_deb_d <= 1'b0;
        end else begin
            r_fire_deb_d <= w_deb[0];
        end
    end

    assign w_fire_rise = w_deb[0] & ~r_fire_deb_d;

    logic [4:0] w_ships;
    logic [3:0] w_shots_dec;

    always_comb begin
        w_ships = '0;
        for (int k = 0; k < 16; k++) begin
            if (grid_state[2*k +: 2] == 2'b01) begin
                w_ships = w_ships + 5'd1;
            end
        end
    end

    state_t     r_state;
    logic [3:0] r_settle_cnt;
    logic [3:0] r_row_en;
    logic [3:0] r_col_en;
    logic       r_fire_pulse;
    logic       r_reject;
    logic [3:0] r_shots_left;
    logic       r_game_over;
    logic       r_win;
    logic       r_busy;

    // Saturating decrement keeps the budget from wrapping below zero.
    assign w_shots_dec = (r_shots_left == 4'd0) ? 4'd0 : r_shots_left - 4'd1;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= S_IDLE;
            r_settle_cnt <= 4'd0;
            r_row_en     <= 4'd0;
            r_col_en     <= 4'd0;
            r_fire_pulse <= 1'b0;
            r_reject     <= 1'b0;
            r_shots_left <= c_MAX_SHOTS;
            r_game_over  <= 1'b0;
            r_win        <= 1'b0;
            r_busy       <= 1'b0;
        end else begin
            r_row_en     <= 4'd0;
            r_col_en     <= 4'd0;
            r_fire_pulse <= 1'b0;
            r_reject     <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_fire_rise) begin
                        if (sel_error || (sel_onehot == 4'd0)) begin
                            r_reject <= 1'b1;
                        end else begin
                            r_state      <= S_FIRE;
                            r_busy       <= 1'b1;
                            r_fire_pulse <= 1'b1;
                            if (w_deb[1]) begin
                                r_col_en <= sel_onehot;
                            end else begin
                                r_row_en <= sel_onehot;
                            end
                        end
                    end
                end
                S_FIRE: begin
                    r_state      <= S_SETTLE;
                    r_settle_cnt <= 4'd0;
                end
                S_SETTLE: begin
                    if (r_settle_cnt == c_SETTLE_LAST) begin
                        r_state <= S_EVAL;
                    end else begin
                        r_settle_cnt <= r_settle_cnt + 4'd1;
                    end
                end
                S_EVAL: begin
                    // An empty board wins even if this was the last shot.
                    if (w_ships == 5'd0) begin
                        r_win       <= 1'b1;
                        r_game_over <= 1'b1;
                        r_state     <= S_DONE;
                    end else begin
                        r_shots_left <= w_shots_dec;
                        if (w_shots_dec == 4'd0) begin
                            r_game_over <= 1'b1;
                            r_win       <= 1'b0;
                            r_state     <= S_DONE;
                        end else begin
                            r_state <= S_IDLE;
                            r_busy  <= 1'b0;
                        end
                    end
                end
                S_DONE: begin
                    if (w_fire_rise) begin
                        r_reject <= 1'b1;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign row_en     = r_row_en;
    assign col_en     = r_col_en;
    assign fire_pulse = r_fire_pulse;
    assign reject     = r_reject;
    assign shots_left = r_shots_left;
    assign game_over  = r_game_over;
    assign win        = r_win;
    assign busy       = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_fire_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_fire_sequencer
// Brief    : Self-checking bench: vector table, corner sequences and random
//            stimulus against a cycle-level behavioural model.
// Revision : 1.0
// ============================================================================
module tb_fire_sequencer;

    localparam int DB  = 4;
    localparam int MAX = 3;
    localparam int ST  = 2;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        fire_btn_raw = 1'b0;
    logic        nrow_raw = 1'b0;
    logic [3:0]  sel_onehot = 4'd0;
    logic        sel_error = 1'b0;
    logic [31:0] grid_state = 32'd0;
    logic [3:0]  row_en;
    logic [3:0]  col_en;
    logic        fire_pulse;
    logic        reject;
    logic [3:0]  shots_left;
    logic        game_over;
    logic        win;
    logic        busy;

    fire_sequencer #(
        .DEBOUNCE_CYCLES (DB),
        .MAX_SHOTS       (MAX),
        .SETTLE_CYCLES   (ST)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .fire_btn_raw (fire_btn_raw),
        .nrow_raw     (nrow_raw),
        .sel_onehot   (sel_onehot),
        .sel_error    (sel_error),
        .grid_state   (grid_state),
        .row_en       (row_en),
        .col_en       (col_en),
        .fire_pulse   (fire_pulse),
        .reject       (reject),
        .shots_left   (shots_left),
        .game_over    (game_over),
        .win          (win),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: button history, run length of disagreement, and
    // a shot "age" counting cycles since the shot was accepted.
    bit        m_valid = 0;
    bit [1:0]  m_hist_f, m_hist_n;
    bit        m_deb_f, m_deb_f_prev, m_deb_n;
    int        m_run_f, m_run_n;
    int        m_age;
    bit        m_done;
    int        m_shots;
    bit [3:0]  m_row, m_col;
    bit        m_fp, m_rej, m_go, m_win, m_busy;

    function automatic int count_ships(input logic [31:0] g);
        int n = 0;
        for (int k = 0; k < 16; k++) if (((g >> (2 * k)) & 32'd3) == 32'd1) n++;
        return n;
    endfunction

    task automatic deb_step(input bit s, inout bit d, inout int run);
        if (s == d) run = 0;
        else begin
            run++;
            if (run == DB) begin
                d   = s;
                run = 0;
            end
        end
    endtask

    task automatic model_step();
        bit rise;
        if (reset) begin
            m_valid = 1;
            m_hist_f = 0; m_hist_n = 0; m_deb_f = 0; m_deb_f_prev = 0; m_deb_n = 0;
            m_run_f = 0; m_run_n = 0; m_age = 0; m_done = 0; m_shots = MAX;
            m_row = 0; m_col = 0; m_fp = 0; m_rej = 0; m_go = 0; m_win = 0; m_busy = 0;
            return;
        end
        rise  = m_deb_f && !m_deb_f_prev;
        m_fp  = 0; m_rej = 0; m_row = 0; m_col = 0;
        if (m_done) begin
            if (rise) m_rej = 1;
        end else if (m_age == 0) begin
            if (rise) begin
                if (sel_error || sel_onehot == 4'd0) m_rej = 1;
                else begin
                    m_age = 1;
                    m_fp  = 1;
                    if (m_deb_n) m_col = sel_onehot;
                    else         m_row = sel_onehot;
                end
            end
        end else if (m_age == 2 + ST) begin
            if (count_ships(grid_state) == 0) begin
                m_win = 1; m_go = 1; m_done = 1;
            end else begin
                if (m_shots > 0) m_shots--;
                if (m_shots == 0) begin
                    m_go = 1; m_done = 1;
                end
            end
            m_age = 0;
        end else begin
            m_age++;
        end
        m_busy = m_done || (m_age != 0);
        m_deb_f_prev = m_deb_f;
        deb_step(m_hist_f[1], m_deb_f, m_run_f);
        deb_step(m_hist_n[1], m_deb_n, m_run_n);
        m_hist_f = {m_hist_f[0], fire_btn_raw};
        m_hist_n = {m_hist_n[0], nrow_raw};
    endtask

    task automatic cyc();
        logic [16:0] act, exp;
        @(posedge clk);
        model_step();
        @(negedge clk);
        if (m_valid) begin
            act = {row_en, col_en, fire_pulse, reject, shots_left, game_over, win, busy};
            exp = {m_row, m_col, m_fp, m_rej, 4'(m_shots), m_go, m_win, m_busy};
            check("cycle", 32'(act), 32'(exp));
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        cyc();
        reset = 1'b0;
    endtask

    task automatic press(input logic nr, input logic [3:0] sel, input logic err,
                         input logic [31:0] g, input logic [31:0] ga,
                         output int nfire, output int nrej, output logic [3:0] rc,
                         output logic [3:0] cc, output int nbusy);
        nrow_raw = nr; sel_onehot = sel; sel_error = err; grid_state = g;
        nfire = 0; nrej = 0; nbusy = 0; rc = 4'd0; cc = 4'd0;
        repeat (10) cyc();
        fire_btn_raw = 1'b1;
        for (int i = 0; i < 30; i++) begin
            cyc();
            if (fire_pulse) begin
                nfire++;
                rc = row_en;
                cc = col_en;
                grid_state = ga;
            end
            if (reject) nrej++;
            if (busy) nbusy++;
            if (i == 12) fire_btn_raw = 1'b0;
        end
    endtask

    typedef struct {
        bit        rst;
        bit        nr;
        bit [3:0]  sel;
        bit        err;
        bit [31:0] g;
        bit [31:0] ga;
        int        e_fire;
        int        e_rej;
        bit [3:0]  e_row;
        bit [3:0]  e_col;
        bit [3:0]  e_shots;
        bit        e_go;
        bit        e_win;
        bit        chk_busy;
        int        e_busy;
    } vec_t;

    localparam logic [31:0] G_SHIP = 32'h0000_0400;
    localparam logic [31:0] G_ONE  = 32'hAAAA_AAA9;
    localparam logic [31:0] G_HIT  = 32'hAAAA_AAAB;

    function automatic logic [31:0] rand_grid();
        logic [31:0] g;
        bit          noship = ($urandom_range(0, 2) == 0);
        for (int k = 0; k < 16; k++) begin
            logic [1:0] c = 2'($urandom_range(0, 3));
            if (noship && c == 2'b01) c = 2'b11;
            g[2*k +: 2] = c;
        end
        return g;
    endfunction

    initial begin
        vec_t       vt[9];
        int         nf, nr, nb;
        logic [3:0] rc, cc;
        int         fr_left, nr_left, seen;

        vt[0] = '{1, 0, 4'b0100, 0, G_SHIP, G_SHIP, 1, 0, 4'b0100, 4'b0000, 4'd2, 0, 0, 1, 4};
        vt[1] = '{0, 0, 4'b0100, 1, G_SHIP, G_SHIP, 0, 1, 4'b0000, 4'b0000, 4'd2, 0, 0, 1, 0};
        vt[2] = '{0, 0, 4'b0000, 0, G_SHIP, G_SHIP, 0, 1, 4'b0000, 4'b0000, 4'd2, 0, 0, 1, 0};
        vt[3] = '{1, 1, 4'b0001, 0, G_ONE,  G_HIT,  1, 0, 4'b0000, 4'b0001, 4'd3, 1, 1, 0, 0};
        vt[4] = '{0, 1, 4'b0001, 0, G_HIT,  G_HIT,  0, 1, 4'b0000, 4'b0000, 4'd3, 1, 1, 0, 0};
        vt[5] = '{1, 0, 4'b1000, 0, G_SHIP, G_SHIP, 1, 0, 4'b1000, 4'b0000, 4'd2, 0, 0, 1, 4};
        vt[6] = '{0, 1, 4'b0010, 0, G_SHIP, G_SHIP, 1, 0, 4'b0000, 4'b0010, 4'd1, 0, 0, 1, 4};
        vt[7] = '{0, 0, 4'b0001, 0, G_SHIP, G_SHIP, 1, 0, 4'b0001, 4'b0000, 4'd0, 1, 0, 0, 0};
        vt[8] = '{0, 0, 4'b0100, 0, G_SHIP, G_SHIP, 0, 1, 4'b0000, 4'b0000, 4'd0, 1, 0, 0, 0};

        cyc();
        do_reset();
        check("reset_state", {row_en, col_en, fire_pulse, reject, shots_left, game_over, win, busy},
              {4'd0, 4'd0, 1'b0, 1'b0, 4'd3, 1'b0, 1'b0, 1'b0});

        for (int v = 0; v < 9; v++) begin
            if (vt[v].rst) do_reset();
            press(vt[v].nr, vt[v].sel, vt[v].err, vt[v].g, vt[v].ga, nf, nr, rc, cc, nb);
            check($sformatf("v%0d_fire", v), nf, vt[v].e_fire);
            check($sformatf("v%0d_reject", v), nr, vt[v].e_rej);
            check($sformatf("v%0d_row_en", v), rc, vt[v].e_row);
            check($sformatf("v%0d_col_en", v), cc, vt[v].e_col);
            check($sformatf("v%0d_shots", v), shots_left, vt[v].e_shots);
            check($sformatf("v%0d_go_win", v), {game_over, win}, {vt[v].e_go, vt[v].e_win});
            if (vt[v].chk_busy) check($sformatf("v%0d_busy", v), nb, vt[v].e_busy);
        end

        // Short glitches on the button never survive the debounce.
        do_reset();
        grid_state = G_SHIP; sel_onehot = 4'b0010; sel_error = 1'b0; nrow_raw = 1'b0;
        repeat (10) cyc();
        nf = 0; nr = 0;
        for (int i = 0; i < 28; i++) begin
            fire_btn_raw = (i < 8) ? 1'(i % 2 == 0) : 1'b0;
            cyc();
            if (fire_pulse) nf++;
            if (reject) nr++;
        end
        check("glitch_fire", nf, 0);
        check("glitch_reject", nr, 0);
        check("glitch_shots", shots_left, 3);

        // Reset landing in SETTLE aborts the shot.
        do_reset();
        repeat (10) cyc();
        fire_btn_raw = 1'b1;
        seen = 0;
        for (int i = 0; i < 30 && seen == 0; i++) begin
            cyc();
            if (fire_pulse) seen = 1;
        end
        check("settle_pulse_seen", seen, 1);
        fire_btn_raw = 1'b0;
        cyc();
        check("settle_busy", busy, 1);
        reset = 1'b1;
        cyc();
        reset = 1'b0;
        check("settle_reset", {row_en, col_en, fire_pulse, reject, shots_left, game_over, win, busy},
              {4'd0, 4'd0, 1'b0, 1'b0, 4'd3, 1'b0, 1'b0, 1'b0});
        repeat (20) cyc();
        check("settle_after", {shots_left, busy}, {4'd3, 1'b0});

        // Random stimulus, checked every cycle against the model.
        fr_left = 0; nr_left = 0;
        for (int i = 0; i < 4000; i++) begin
            if (fr_left == 0) begin
                fire_btn_raw = 1'($urandom_range(0, 1));
                fr_left = $urandom_range(1, 10);
            end
            fr_left--;
            if (nr_left == 0) begin
                nrow_raw = 1'($urandom_range(0, 1));
                nr_left = $urandom_range(1, 20);
            end
            nr_left--;
            case ($urandom_range(0, 3))
                0:       sel_onehot = 4'd0;
                3:       sel_onehot = 4'($urandom_range(0, 15));
                default: sel_onehot = 4'(1 << $urandom_range(0, 3));
            endcase
            sel_error = ($urandom_range(0, 7) == 0);
            if ($urandom_range(0, 15) == 0) grid_state = rand_grid();
            reset = ($urandom_range(0, 299) == 0);
            cyc();
        end
        reset = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
